riscv_fetch_stage: RTL and testbench

Instruction fetch stage feeding the decode stage of the `RISCVCPU` pipeline. It owns the PC, issues sequential word reads to a 1-cycle-latency instruction memory, and buffers returned instructions in a small FIFO so decode stalls (load-use) do not lose fetched words. A redirect input (branch/jump resolved downstream) flushes all buffered and in-flight instructions and restarts fetch at a new PC.

---
 rtl/riscv_fetch_stage_if.sv | 39 +++
 rtl/riscv_fetch_stage.sv | 137 +++++++++++++
 tb/tb_riscv_fetch_stage.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_fetch_stage_if.sv
// Fetch stage bus: instruction-memory request/response, decode handshake and redirect.
// master = fetch stage side, slave = memory/decode/branch-resolution side.
interface riscv_fetch_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    output redirect,
    output redirect_pc
  );
endinterface

// File: rtl/riscv_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues sequential word reads to a 1-cycle-latency
// instruction memory and buffers responses in a small prefetch FIFO for the decode stage.
// A redirect flushes buffered and in-flight words and restarts fetch at a new PC.
//
// Optional feature: define FETCH_BYPASS_EN to forward a response straight to the decode
// outputs when the FIFO is empty (saves one cycle of fetch latency). Without it the decode
// outputs always come from the FIFO.
module riscv_fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic               clock,
  input logic               reset,
  riscv_fetch_stage_if.master bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = CW + 1;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] pc_q;
  logic            inflight_q;
  logic [XLEN-1:0] inflight_pc_q;

  logic [XLEN-1:0] fifo_pc_q    [DEPTH];
  logic [XLEN-1:0] fifo_instr_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [CW-1:0]   count_q;

  logic            fifo_empty;
  logic            bypass;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic            pop;
  logic            pop_fifo;
  logic            push_fifo;
  logic [OW-1:0]   occupancy;
  logic            issue;

  // Low address bits of a redirect target are ignored by design.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  // Select what decode sees: FIFO head, live response (bypass), or a NOP bubble.
  always_comb begin
    fifo_empty = (count_q == '0);
`ifdef FETCH_BYPASS_EN
    bypass     = fifo_empty && inflight_q;
`else
    bypass     = 1'b0;
`endif
    out_valid  = 1'b0;
    out_pc     = pc_q;
    out_instr  = NOP;
    if (!fifo_empty) begin
      out_valid = 1'b1;
      out_pc    = fifo_pc_q[rd_ptr_q];
      out_instr = fifo_instr_q[rd_ptr_q];
    end else if (bypass) begin
      out_valid = 1'b1;
      out_pc    = inflight_pc_q;
      out_instr = bus.imem_rdata;
    end
  end

  // Handshake and issue decisions; the issue rule keeps FIFO + in-flight within DEPTH.
  always_comb begin
    pop       = out_valid && bus.if_ready && !bus.redirect;
    pop_fifo  = pop && !fifo_empty;
    // A bypassed response that decode takes this cycle never needs a FIFO slot.
    push_fifo = inflight_q && !bus.redirect && !(bypass && pop);
    occupancy = OW'(count_q) + OW'(inflight_q) - OW'(pop);
    issue     = !reset && !bus.redirect && (occupancy < OW'(DEPTH));
  end

  assign bus.imem_req  = issue;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = out_valid;
  assign bus.if_pc     = out_pc;
  assign bus.if_instr  = out_instr;

  // PC and in-flight tracking; a redirect drops the pending response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else if (bus.redirect) begin
      pc_q       <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q          <= pc_q + XLEN'(4);
        inflight_pc_q <= pc_q;
      end
    end
  end

  // FIFO pointers and fill level; a redirect empties the FIFO.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_fifo) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_fifo) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_fifo, pop_fifo})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage; contents are only observed while count_q says they are valid.
  always_ff @(posedge clock) begin
    if (push_fifo) begin
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
      fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
    end
  end

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Self-checking bench for riscv_fetch_stage: a scoreboard queue of expected fetch PCs is
// filled by the directed stimulus and drained by a monitor on every decode handshake.
module tb_riscv_fetch_stage;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_pc;

  riscv_fetch_stage_if #(.XLEN(32)) bus ();

  riscv_fetch_stage #(
    .XLEN    (32),
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00:  mem_word = 32'h0050_0093;
      32'h04:  mem_word = 32'h00A0_0113;
      32'h08:  mem_word = 32'h0020_81B3;
      32'h0C:  mem_word = 32'h4031_8233;
      32'h10:  mem_word = 32'h0042_22B3;
      32'h14:  mem_word = 32'h0052_A333;
      default: mem_word = 32'hC0DE_0000 ^ a;
    endcase
  endfunction

  // Instruction memory: 1-cycle read latency, garbage when not requested.
  always @(posedge clock) begin
    bus.imem_rdata <= bus.imem_req ? mem_word(bus.imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted instruction must be the next expected one.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.imem_req) check("imem_addr_align", {30'd0, bus.imem_addr[1:0]}, 32'd0);
      if (!bus.if_valid) check("nop_when_invalid", bus.if_instr, NOP);
      if (bus.if_valid && bus.if_ready && !bus.redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL accept_unexpected: got pc %h, required no accept", bus.if_pc);
        end else begin
          mon_pc = exp_q.pop_front();
          check("accept_pc", bus.if_pc, mon_pc);
          check("accept_instr", bus.if_instr, mem_word(mon_pc));
        end
      end
      if (dut.push_fifo && !dut.pop_fifo && int'(dut.count_q) == DEPTH) begin
        errors++;
        $display("FAIL fifo_overflow: got push into full FIFO, required none");
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clock);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Called in the redirect cycle (redirect=1 already driven); checks restart timing.
  task automatic follow(input string name, input logic [31:0] target);
    tick();
    bus.redirect = 1'b0;
    at_neg();
    check({name, "_req_r1"}, 32'(bus.imem_req), 32'd1);
    check({name, "_addr_r1"}, bus.imem_addr, target);
    check({name, "_valid_r1"}, 32'(bus.if_valid), 32'd0);
    tick();
    at_neg();
    check({name, "_addr_r2"}, bus.imem_addr, target + 32'd4);
    check({name, "_valid_r2"}, 32'(bus.if_valid), (LAT == 1) ? 32'd1 : 32'd0);
    if (LAT == 2) begin
      tick();
      at_neg();
    end
    check({name, "_first_valid"}, 32'(bus.if_valid), 32'd1);
    check({name, "_first_pc"}, bus.if_pc, target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    bus.if_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    tick();
    tick();
    at_neg();
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_imem_addr", bus.imem_addr, 32'h0);
    check("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check("rst_if_instr", bus.if_instr, NOP);
    check("rst_if_pc", bus.if_pc, 32'h0);

    // Six instructions streamed back to back.
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    bus.if_ready = 1'b1;
    tick();
    reset = 1'b0;
    at_neg();
    check("t1_req_c0", 32'(bus.imem_req), 32'd1);
    check("t1_addr_c0", bus.imem_addr, 32'h0);
    check("t1_valid_c0", 32'(bus.if_valid), 32'd0);
    for (int c = 1; c <= LAT + 5; c++) begin
      tick();
      at_neg();
      check("t1_valid", 32'(bus.if_valid), (c >= LAT) ? 32'd1 : 32'd0);
    end
    tick();
    bus.if_ready = 1'b0;
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // Reset for one cycle while an instruction is presented.
    tick();
    tick();
    tick();
    at_neg();
    check("t5_pre_valid", 32'(bus.if_valid), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    check("t5_valid", 32'(bus.if_valid), 32'd0);
    check("t5_instr", bus.if_instr, NOP);
    check("t5_req", 32'(bus.imem_req), 32'd0);
    check("t5_pc", bus.if_pc, 32'h0);

    // Refetch from reset PC, then stall decode while the 2nd instruction is presented.
    for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
    bus.if_ready = 1'b1;
    tick();
    reset = 1'b0;
    at_neg();
    check("t2_req_c0", 32'(bus.imem_req), 32'd1);
    check("t2_addr_c0", bus.imem_addr, 32'h0);
    for (int c = 1; c <= LAT; c++) tick();
    at_neg();
    check("t2_first_valid", 32'(bus.if_valid), 32'd1);
    check("t2_first_pc", bus.if_pc, 32'h0);
    tick();
    bus.if_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      check("t2_stall_valid", 32'(bus.if_valid), 32'd1);
      check("t2_stall_pc", bus.if_pc, 32'h4);
      check("t2_stall_instr", bus.if_instr, 32'h00A0_0113);
      if (k == 3) check("t2_stall_req", 32'(bus.imem_req), 32'd0);
      tick();
    end
    bus.if_ready = 1'b1;
    wait_drain("t2");

    // Redirect with words buffered and a response in flight.
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h40;
    at_neg();
    check("t3_req_redirect", 32'(bus.imem_req), 32'd0);
    follow("t3", 32'h40);
    wait_drain("t3");

    // Misaligned redirect target is forced to a word boundary.
    exp_q.push_back(32'h40);
    exp_q.push_back(32'h44);
    exp_q.push_back(32'h48);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h43;
    at_neg();
    check("t4_req_redirect", 32'(bus.imem_req), 32'd0);
    follow("t4", 32'h40);
    wait_drain("t4");

    // PC wraps past the top of the address space.
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    at_neg();
    check("t6_req_redirect", 32'(bus.imem_req), 32'd0);
    follow("t6", 32'hFFFF_FFFC);
    wait_drain("t6");
    bus.if_ready = 1'b0;

    // Indefinite stall: fetch stops and the head stays put.
    for (int i = 0; i < 6; i++) tick();
    for (int k = 0; k < 5; k++) begin
      at_neg();
      check("hold_req", 32'(bus.imem_req), 32'd0);
      check("hold_valid", 32'(bus.if_valid), 32'd1);
      check("hold_pc", bus.if_pc, 32'h8);
      check("hold_instr", bus.if_instr, mem_word(32'h8));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
